// File: rtl/acc_pool_pkg.sv
// Shared types and default widths for the pooled-result read-back sequencer.
package acc_pool_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_SA_ADDR_WIDTH   = 14;
  localparam int DEF_FC_ADDR_WIDTH   = 10;
  localparam int DEF_POOL_ADDR_WIDTH = 10;
  localparam int DEF_FIFO_DEPTH      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_SA = 1'b0;
  localparam logic MODE_FC = 1'b1;

  // One buffered beat at the default widths: {data, addr, last}.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]      data;
    logic [DEF_POOL_ADDR_WIDTH-1:0] addr;
    logic                           last;
  } fifo_entry_t;

endpackage

// File: rtl/pool_rd_sequencer_if.sv
// Control, BRAM read-port and output-stream bundle of the read-back sequencer.
// Stream handshake: a beat moves on a rising edge where out_valid_o and
// out_ready_i are both high; once out_valid_o rises it and the payload
// (out_data_o, out_addr_o, out_last_o) hold until that transfer.
interface pool_rd_sequencer_if
  import acc_pool_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SA_ADDR_WIDTH   = DEF_SA_ADDR_WIDTH,
  parameter int FC_ADDR_WIDTH   = DEF_FC_ADDR_WIDTH,
  parameter int POOL_ADDR_WIDTH = DEF_POOL_ADDR_WIDTH
);
  logic                       start_i;
  logic                       mode_i;
  logic [SA_ADDR_WIDTH-1:0]   base_i;
  logic [SA_ADDR_WIDTH:0]     len_i;
  logic                       busy_o;
  logic                       done_o;
  logic [1:0]                 state_dbg_o;

  logic                       sa_data_rden_o;
  logic [SA_ADDR_WIDTH-1:0]   sa_data_rdptr_o;
  logic [DATA_WIDTH-1:0]      sa_data_rdata_i;
  logic                       pool_address_rden_o;
  logic [SA_ADDR_WIDTH-1:0]   pool_address_rdptr_o;
  logic [POOL_ADDR_WIDTH-1:0] pool_address_rdata_i;
  logic                       fc_data_rden_o;
  logic [FC_ADDR_WIDTH-1:0]   fc_data_rdptr_o;
  logic [DATA_WIDTH-1:0]      fc_data_rdata_i;

  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [DATA_WIDTH-1:0]      out_data_o;
  logic [POOL_ADDR_WIDTH-1:0] out_addr_o;
  logic                       out_last_o;

  modport master (
    input  start_i, mode_i, base_i, len_i,
    output busy_o, done_o, state_dbg_o,
    output sa_data_rden_o, sa_data_rdptr_o, input sa_data_rdata_i,
    output pool_address_rden_o, pool_address_rdptr_o, input pool_address_rdata_i,
    output fc_data_rden_o, fc_data_rdptr_o, input fc_data_rdata_i,
    output out_valid_o, out_data_o, out_addr_o, out_last_o,
    input  out_ready_i
  );

  modport slave (
    output start_i, mode_i, base_i, len_i,
    input  busy_o, done_o, state_dbg_o,
    input  sa_data_rden_o, sa_data_rdptr_o, output sa_data_rdata_i,
    input  pool_address_rden_o, pool_address_rdptr_o, output pool_address_rdata_i,
    input  fc_data_rden_o, fc_data_rdptr_o, output fc_data_rdata_i,
    input  out_valid_o, out_data_o, out_addr_o, out_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/pool_rd_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide,
// including on a full buffer where the count then stays unchanged.
module pool_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Flags and head-of-queue read; a push on full is only taken alongside a pop.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    pop_data = mem[rd_ptr];
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pool_rd_sequencer.sv
// Reads a contiguous run of pooled results out of the SA (data + pool address)
// or FC BRAMs and re-times the 1-cycle BRAM latency into a valid/ready stream.
// Reads are only issued while buffer occupancy plus the in-flight read leaves
// room, so a returning word always has a slot.
module pool_rd_sequencer
  import acc_pool_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SA_ADDR_WIDTH   = DEF_SA_ADDR_WIDTH,
  parameter int FC_ADDR_WIDTH   = DEF_FC_ADDR_WIDTH,
  parameter int POOL_ADDR_WIDTH = DEF_POOL_ADDR_WIDTH,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  pool_rd_sequencer_if.master bus
);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW   = SA_ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      data;
    logic [POOL_ADDR_WIDTH-1:0] addr;
    logic                       last;
  } entry_t;

  logic [1:0]               state_q, state_d;
  logic                     mode_q;
  logic [SA_ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            issued_q;
  logic                     inflight_q;
  logic                     inflight_last_q;
  logic [SA_ADDR_WIDTH-1:0] sa_ptr_q, sa_ptr_next;
  logic [FC_ADDR_WIDTH-1:0] fc_ptr_q, fc_ptr_next;
  logic [CNTW-1:0]          fifo_count, credit_used;
  logic                     fifo_full, fifo_empty;
  logic                     issue, issue_last, sa_rden, fc_rden;
  logic                     push, pop;
  entry_t                   push_entry, pop_entry;

  // Credit check and next read pointers, all from registered state.
  always_comb begin
    credit_used = fifo_count + CNTW'(inflight_q);
    issue       = (state_q == S_RUN) && (credit_used < CNTW'(FIFO_DEPTH));
    issue_last  = (issued_q == len_q - LW'(1));
    sa_ptr_next = base_q + issued_q[SA_ADDR_WIDTH-1:0];
    fc_ptr_next = base_q[FC_ADDR_WIDTH-1:0] + issued_q[FC_ADDR_WIDTH-1:0];
    sa_rden     = issue && (mode_q == MODE_SA);
    fc_rden     = issue && (mode_q == MODE_FC);
  end

  // BRAM ports: pointers show the issuing address, otherwise the last one used.
  always_comb begin
    bus.sa_data_rden_o       = sa_rden;
    bus.sa_data_rdptr_o      = sa_rden ? sa_ptr_next : sa_ptr_q;
    bus.pool_address_rden_o  = sa_rden;
    bus.pool_address_rdptr_o = sa_rden ? sa_ptr_next : sa_ptr_q;
    bus.fc_data_rden_o       = fc_rden;
    bus.fc_data_rdptr_o      = fc_rden ? fc_ptr_next : fc_ptr_q;
  end

  // Capture the word returning from last cycle's read; FC beats carry their index.
  always_comb begin
    push            = inflight_q;
    push_entry.data = (mode_q == MODE_FC) ? bus.fc_data_rdata_i : bus.sa_data_rdata_i;
    push_entry.addr = (mode_q == MODE_FC) ? POOL_ADDR_WIDTH'(fc_ptr_q) : bus.pool_address_rdata_i;
    push_entry.last = inflight_last_q;
    pop             = !fifo_empty && bus.out_ready_i;
  end

  pool_rd_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (pop_entry),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Stream and status outputs; payload is forced to zero while nothing is valid.
  always_comb begin
    bus.out_valid_o = !fifo_empty;
    bus.out_data_o  = fifo_empty ? '0 : pop_entry.data;
    bus.out_addr_o  = fifo_empty ? '0 : pop_entry.addr;
    bus.out_last_o  = !fifo_empty && pop_entry.last;
    bus.busy_o      = (state_q != S_IDLE);
    bus.done_o      = (state_q == S_DONE);
    bus.state_dbg_o = state_q;
  end

  // Next-state: DRAIN exits as the final beat leaves so done lands one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = (bus.len_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issue && issue_last) state_d = S_DRAIN;
      S_DRAIN: if (!inflight_q && (fifo_empty || (fifo_count == CNTW'(1) && pop)))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operation context, issue counter, last-issued pointers and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q          <= MODE_SA;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      sa_ptr_q        <= '0;
      fc_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.start_i) begin
        mode_q   <= bus.mode_i;
        base_q   <= bus.base_i;
        len_q    <= bus.len_i;
        issued_q <= '0;
      end
      if (issue) begin
        issued_q <= issued_q + LW'(1);
        if (mode_q == MODE_FC) fc_ptr_q <= fc_ptr_next;
        else                   sa_ptr_q <= sa_ptr_next;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
    end
  end

  // A returning word must never meet a full buffer without a simultaneous pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule
